sync_gen: RTL and testbench

- Downstream consumer of the control-register file's `sync_en` bit. When enabled, it emits a periodic sync pulse train aligned to the sample strobe.
- It also counts emitted pulses and enabled sample frames.
- `sync_out` is the pulse train that drives the experiment rig. `sync_in` feeds the register file's `sync_in` input for host readback.
- It sits between the register file and the acquisition front end.

---
 rtl/sync_gen_pkg.sv | 8 +
 rtl/sync_pulse_stretch.sv | 30 +++
 rtl/sync_gen.sv | 96 +++++++++
 tb/tb_sync_gen.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sync_gen_pkg.sv
// sync_gen_pkg: shared FSM state type and default widths for the sync pulse generator.
package sync_gen_pkg;
  typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;
  localparam int DEF_PERIOD_W = 16;
  localparam int DEF_LEN_W    = 8;
  localparam int DEF_CNT_W    = 32;
  localparam int MIN_PERIOD   = 1;
endpackage

// File: rtl/sync_pulse_stretch.sv
// sync_pulse_stretch: retriggerable registered pulse, high for max(len,1) cycles after each start.
module sync_pulse_stretch #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             pulse,
  output logic             more
);
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             pulse_q, pulse_d;
  // more: the pulse continues past the current cycle
  assign more  = rem_q > LEN_W'(1);
  assign pulse = pulse_q;
  always_comb begin
    rem_d   = start ? (len == '0 ? LEN_W'(1) : len) : (rem_q != '0 ? rem_q - LEN_W'(1) : rem_q);
    pulse_d = start | more;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      pulse_q <= pulse_d;
    end
  end
endmodule

// File: rtl/sync_gen.sv
// sync_gen: periodic sync pulse train aligned to sample strobes, with pulse/frame counters.
// Define SYNC_GEN_EXT_TRIG_EN to add the asynchronous ext_trig pulse-start input.
module sync_gen
  import sync_gen_pkg::*;
#(
  parameter int PERIOD_W = DEF_PERIOD_W,
  parameter int LEN_W    = DEF_LEN_W,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sync_en,
  input  logic                sample_stb,
  input  logic [PERIOD_W-1:0] period,
  input  logic [LEN_W-1:0]    pulse_len,
`ifdef SYNC_GEN_EXT_TRIG_EN
  input  logic                ext_trig,
`endif
  output logic                sync_out,
  output logic                sync_in,
  output logic                busy,
  output logic [CNT_W-1:0]    frame_cnt,
  output logic [15:0]         sync_cnt
);
  state_t              state_q, state_d;
  logic                en_q, sync_in_q, more, trig;
  logic                rise, arm_go, run_on, run_stb, start;
  logic [PERIOD_W-1:0] per_q, per_d, smp_q, smp_d;
  logic [CNT_W-1:0]    frame_q, frame_d;
  logic [15:0]         scnt_q, scnt_d;
`ifdef SYNC_GEN_EXT_TRIG_EN
  logic [2:0] trig_q;
  // two synchronizer stages, third stage for rising-edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trig_q <= '0;
    else        trig_q <= {trig_q[1:0], ext_trig};
  end
  assign trig = trig_q[1] & ~trig_q[2];
`else
  assign trig = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      en_q      <= 1'b0;
      sync_in_q <= 1'b0;
      per_q     <= '0;
      smp_q     <= '0;
      frame_q   <= '0;
      scnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      en_q      <= sync_en;
      sync_in_q <= sync_out;
      per_q     <= per_d;
      smp_q     <= smp_d;
      frame_q   <= frame_d;
      scnt_q    <= scnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = rise ? ARM : IDLE;
      ARM:     state_d = !sync_en ? IDLE : sample_stb ? RUN : ARM;
      RUN:     state_d = sync_en ? RUN : DRAIN;
      DRAIN:   state_d = more ? DRAIN : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    rise    = sync_en & ~en_q;
    arm_go  = state_q == ARM && sync_en && sample_stb;
    run_on  = state_q == RUN && sync_en;
    run_stb = run_on && sample_stb;
    start   = arm_go | (run_stb & (smp_q == per_q)) | (run_on & trig);
    per_d   = state_q == ARM ? (period == '0 ? PERIOD_W'(MIN_PERIOD) : period) : per_q;
    smp_d   = start ? PERIOD_W'(1) : run_stb ? smp_q + PERIOD_W'(1) : smp_q;
    frame_d = (state_q == IDLE && rise) ? '0 : (arm_go | run_stb) ? frame_q + CNT_W'(1) : frame_q;
    scnt_d  = (state_q == IDLE && rise) ? '0 : start ? scnt_q + 16'd1 : scnt_q;
  end
  always_comb begin
    busy      = state_q != IDLE;
    sync_in   = sync_in_q;
    frame_cnt = frame_q;
    sync_cnt  = scnt_q;
  end
  sync_pulse_stretch #(.LEN_W(LEN_W)) u_stretch (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .len   (pulse_len),
    .pulse (sync_out),
    .more  (more)
  );
endmodule

// File: tb/tb_sync_gen.sv
// tb_sync_gen: table-driven vectors plus directed multi-cycle sequences for sync_gen.
module tb_sync_gen;
  logic        clk = 1'b0, rst_n = 1'b0, sync_en = 1'b0, sample_stb = 1'b0, ext_trig = 1'b0;
  logic [15:0] period = '0;
  logic [7:0]  pulse_len = '0;
  logic        sync_out, sync_in, busy;
  logic [31:0] frame_cnt;
  logic [15:0] sync_cnt;
  int checks = 0, fails = 0;

  sync_gen dut (
    .clk(clk), .rst_n(rst_n), .sync_en(sync_en), .sample_stb(sample_stb),
    .period(period), .pulse_len(pulse_len),
`ifdef SYNC_GEN_EXT_TRIG_EN
    .ext_trig(ext_trig),
`endif
    .sync_out(sync_out), .sync_in(sync_in), .busy(busy),
    .frame_cnt(frame_cnt), .sync_cnt(sync_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en, stb;
    logic [15:0] per;
    logic [7:0]  len;
    logic        out, si, bsy;
    logic [15:0] scnt;
    logic [31:0] fcnt;
  } vec_t;
  vec_t vecs[12];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic go_idle;
    int n;
    sync_en = 0;
    sample_stb = 0;
    n = 0;
    tick;
    while (busy && n < 40) begin
      tick;
      n++;
    end
    chk("idle_bound", {31'd0, busy}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int hc, lows;
    logic first;
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[1]  = '{1, 1, 0, 0, 1, 0, 1, 1, 1};
    vecs[2]  = '{1, 0, 0, 0, 0, 1, 1, 1, 1};
    vecs[3]  = '{1, 1, 0, 0, 1, 0, 1, 2, 2};
    vecs[4]  = '{1, 1, 0, 0, 1, 1, 1, 3, 3};
    vecs[5]  = '{1, 0, 0, 0, 0, 1, 1, 3, 3};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 1, 3, 3};
    vecs[7]  = '{1, 0, 0, 0, 0, 0, 0, 3, 3};
    vecs[8]  = '{1, 1, 0, 0, 0, 0, 0, 3, 3};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 3, 3};
    vecs[10] = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[11] = '{0, 1, 0, 0, 0, 0, 0, 0, 0};

    tick;
    tick;
    chk("rst_out", {31'd0, sync_out}, 0);
    chk("rst_si", {31'd0, sync_in}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_scnt", {16'd0, sync_cnt}, 0);
    chk("rst_fcnt", frame_cnt, 0);
    rst_n = 1;

    // zero period/length, disable, re-enable in DRAIN, drop in ARM
    for (int i = 0; i < 12; i++) begin
      sync_en = vecs[i].en;
      sample_stb = vecs[i].stb;
      period = vecs[i].per;
      pulse_len = vecs[i].len;
      tick;
      chk($sformatf("vec%0d_out", i), {31'd0, sync_out}, {31'd0, vecs[i].out});
      chk($sformatf("vec%0d_si", i), {31'd0, sync_in}, {31'd0, vecs[i].si});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].bsy});
      chk($sformatf("vec%0d_scnt", i), {16'd0, sync_cnt}, {16'd0, vecs[i].scnt});
      chk($sformatf("vec%0d_fcnt", i), frame_cnt, vecs[i].fcnt);
    end
    sample_stb = 0;
    tick;

    // basic run: period 4, length 3, strobe every 10 clk
    period = 4;
    pulse_len = 3;
    sync_en = 1;
    tick;
    for (int k = 1; k <= 8; k++) begin
      sample_stb = 1;
      tick;
      first = sync_out;
      hc = sync_out;
      sample_stb = 0;
      for (int j = 0; j < 9; j++) begin
        tick;
        hc += sync_out;
      end
      chk($sformatf("basic_first%0d", k), {31'd0, first}, (k % 4 == 1) ? 1 : 0);
      chk($sformatf("basic_width%0d", k), hc, (k % 4 == 1) ? 3 : 0);
    end
    chk("basic_scnt", {16'd0, sync_cnt}, 2);
    chk("basic_fcnt", frame_cnt, 8);

    // retrigger: pulse longer than strobe spacing stays high
    go_idle;
    period = 1;
    pulse_len = 20;
    sync_en = 1;
    tick;
    lows = 0;
    for (int k = 1; k <= 5; k++) begin
      sample_stb = 1;
      tick;
      lows += (sync_out ? 0 : 1);
      chk($sformatf("retrig_scnt%0d", k), {16'd0, sync_cnt}, k);
      sample_stb = 0;
      for (int j = 0; j < 9; j++) begin
        tick;
        lows += (sync_out ? 0 : 1);
      end
    end
    chk("retrig_lows", lows, 0);

    // disable on 2nd cycle of a 5-cycle pulse
    go_idle;
    period = 1;
    pulse_len = 5;
    sync_en = 1;
    tick;
    sample_stb = 1;
    tick;
    chk("dis_p1", {31'd0, sync_out}, 1);
    sample_stb = 0;
    tick;
    chk("dis_p2", {31'd0, sync_out}, 1);
    sync_en = 0;
    for (int p = 3; p <= 5; p++) begin
      tick;
      chk($sformatf("dis_p%0d", p), {31'd0, sync_out}, 1);
      chk($sformatf("dis_busy%0d", p), {31'd0, busy}, 1);
    end
    tick;
    chk("dis_end_out", {31'd0, sync_out}, 0);
    chk("dis_end_busy", {31'd0, busy}, 0);
    sample_stb = 1;
    tick;
    sample_stb = 0;
    tick;
    chk("dis_after_out", {31'd0, sync_out}, 0);

    // asynchronous reset mid-pulse
    period = 1;
    pulse_len = 10;
    sync_en = 1;
    tick;
    sample_stb = 1;
    tick;
    sample_stb = 0;
    tick;
    chk("arst_pre_si", {31'd0, sync_in}, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_out", {31'd0, sync_out}, 0);
    chk("arst_si", {31'd0, sync_in}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_scnt", {16'd0, sync_cnt}, 0);
    sync_en = 0;
    rst_n = 1;
    tick;
    tick;
    tick;
    chk("arst_idle_busy", {31'd0, busy}, 0);
    chk("arst_idle_out", {31'd0, sync_out}, 0);
    sync_en = 1;
    tick;
    chk("arst_rearm", {31'd0, busy}, 1);
    sample_stb = 1;
    tick;
    sample_stb = 0;
    chk("arst_pulse", {31'd0, sync_out}, 1);

`ifdef SYNC_GEN_EXT_TRIG_EN
    // external trigger: strobe on even cycles, ext edge after sample 30, then coincident with a match
    go_idle;
    period = 100;
    pulse_len = 2;
    sync_en = 1;
    tick;
    for (int c = 0; c < 470; c++) begin
      sample_stb = (c % 2 == 0);
      ext_trig = (c >= 59 && c < 62) || (c >= 458 && c < 461);
      tick;
      if (c == 60) chk("ext_pre", {31'd0, sync_out}, 0);
      if (c == 61) chk("ext_rise", {31'd0, sync_out}, 1);
      if (c == 61) chk("ext_scnt", {16'd0, sync_cnt}, 2);
      if (c == 200) chk("ext_no101", {16'd0, sync_cnt}, 2);
      if (c == 259) chk("ext_gap", {31'd0, sync_out}, 0);
      if (c == 260) chk("ext_next_out", {31'd0, sync_out}, 1);
      if (c == 260) chk("ext_next_scnt", {16'd0, sync_cnt}, 3);
      if (c == 460) chk("ext_coinc", {16'd0, sync_cnt}, 4);
      if (c == 469) chk("ext_coinc_hold", {16'd0, sync_cnt}, 4);
    end
    sample_stb = 0;
    ext_trig = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
